ifetch_queue_unit: RTL and testbench

Parametrised instruction-fetch stage: owns the fetch PC, a direct-mapped instruction cache, and an in-order instruction queue that decouples fetch from the dispatcher. It fetches on a cache miss through the memory controller, obtains next-PC predictions from the predictor, and keeps running ahead of the dispatcher until the queue fills. It sits between memctrl/predictor and the dispatcher. The ROB redirects it on mispredict.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/ifetch_fifo.sv | 54 +++++
 rtl/ifetch_queue_unit.sv | 195 +++++++++++++++++++
 tb/tb_ifetch_queue_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM states and icache geometry helpers.
package fetch_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MISS = 1'b1
    } fetch_state_e;

    // Index bits needed to address one instruction per cache line.
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag bits left after dropping the byte offset and the index.
    function automatic int tag_w(input int addr_w, input int lines);
        return addr_w - 2 - $clog2(lines);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// In-order instruction queue: synchronous FIFO of arbitrary entry type.
// Pointers wrap naturally (DEPTH is a power of two); count is one bit wider.
module ifetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  logic   pop_i,
    input  logic   clear_i,
    input  entry_t push_data_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; clear wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ifetch_queue_unit.sv
// Instruction fetch stage: fetch PC, direct-mapped icache, miss handling
// through the memory controller, and the queue feeding the dispatcher.
module ifetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int INS_W    = 32,
    parameter int IC_LINES = 256,
    parameter int IQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic [ADDR_W-1:0] pc_to_predictor,
    output logic [INS_W-1:0]  code_to_predictor,
    input  logic              pred_jump_from_predictor,
    input  logic [ADDR_W-1:0] pc_pred_from_predictor,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ok,
    input  logic [INS_W-1:0]  mem_ins,
    output logic              dsp_valid,
    input  logic              dsp_ready,
    output logic [ADDR_W-1:0] dsp_pc,
    output logic [INS_W-1:0]  dsp_ins,
    output logic [ADDR_W-1:0] dsp_pc_pred,
    output logic              dsp_pred_jump,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc
);
    localparam int IDXW = idx_w(IC_LINES);
    localparam int TAGW = tag_w(ADDR_W, IC_LINES);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INS_W-1:0]  ins;
        logic              pred_jump;
        logic [ADDR_W-1:0] pc_pred;
    } iq_entry_t;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              discard_q, discard_d;
    logic [ADDR_W-1:0] pred_pc_q;
    logic [INS_W-1:0]  pred_code_q;

    logic [IC_LINES-1:0] valid_q;
    logic [TAGW-1:0]     tag_mem_q  [IC_LINES];
    logic [INS_W-1:0]    data_mem_q [IC_LINES];

    logic [IDXW-1:0]   look_idx, fill_idx;
    logic [TAGW-1:0]   look_tag, fill_tag;
    logic              hit, lookup, fill, resolve, enq, deq;
    logic [ADDR_W-1:0] res_pc;
    logic [INS_W-1:0]  res_ins;
    logic              iq_full, iq_empty;
    iq_entry_t         iq_push, iq_head;

    assign look_idx = pc_q[2 +: IDXW];
    assign look_tag = pc_q[2+IDXW +: TAGW];
    assign fill_idx = mem_addr_q[2 +: IDXW];
    assign fill_tag = mem_addr_q[2+IDXW +: TAGW];

    assign hit    = valid_q[look_idx] && (tag_mem_q[look_idx] == look_tag);
    assign lookup = rdy && (state_q == ST_RUN) && !iq_full;
    assign fill   = rdy && (state_q == ST_MISS) && mem_ok;

    // The instruction resolved this cycle comes from a hit or a live fill.
    assign resolve = (lookup && hit) || (fill && !discard_q);
    assign res_pc  = fill ? mem_addr_q : pc_q;
    assign res_ins = fill ? mem_ins : data_mem_q[look_idx];

    assign pc_to_predictor   = resolve ? res_pc  : pred_pc_q;
    assign code_to_predictor = resolve ? res_ins : pred_code_q;

    assign enq = resolve && !flush;
    assign deq = rdy && dsp_valid && dsp_ready && !flush;
    assign iq_push = '{pc: res_pc, ins: res_ins,
                       pred_jump: pred_jump_from_predictor,
                       pc_pred: pc_pred_from_predictor};

    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign dsp_valid     = !iq_empty;
    assign dsp_pc        = dsp_valid ? iq_head.pc        : '0;
    assign dsp_ins       = dsp_valid ? iq_head.ins       : '0;
    assign dsp_pc_pred   = dsp_valid ? iq_head.pc_pred   : '0;
    assign dsp_pred_jump = dsp_valid ? iq_head.pred_jump : 1'b0;

    // Next-state logic: hit/miss in RUN, fill return in MISS, then flush on top.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        discard_d  = discard_q;
        if (rdy) begin
            case (state_q)
                ST_RUN: begin
                    if (!iq_full) begin
                        if (hit) begin
                            pc_d = pc_pred_from_predictor;
                        end else begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = pc_q;
                            state_d    = ST_MISS;
                        end
                    end
                end
                ST_MISS: begin
                    if (mem_ok) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_RUN;
                        if (discard_q) discard_d = 1'b0;
                        else           pc_d      = pc_pred_from_predictor;
                    end
                end
                default: state_d = ST_RUN;
            endcase
            // An outstanding request cannot be cancelled, so its reply is
            // marked for discard; otherwise any new miss is abandoned.
            if (flush) begin
                pc_d = flush_pc;
                if ((state_q == ST_MISS) && !mem_ok) begin
                    discard_d = 1'b1;
                end else begin
                    state_d    = ST_RUN;
                    mem_req_d  = 1'b0;
                    mem_addr_d = mem_addr_q;
                    discard_d  = 1'b0;
                end
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            discard_q  <= discard_d;
        end
    end

    // Hold the last resolved pair so the predictor inputs stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_pc_q   <= '0;
            pred_code_q <= '0;
        end else if (resolve) begin
            pred_pc_q   <= res_pc;
            pred_code_q <= res_ins;
        end
    end

    // Line valid bits: cleared only by reset, set by every fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       valid_q <= '0;
        else if (fill) valid_q[fill_idx] <= 1'b1;
    end

    // Tag and data arrays; fills are written even when flushed.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem_q[fill_idx]  <= fill_tag;
            data_mem_q[fill_idx] <= mem_ins;
        end
    end

    ifetch_fifo #(
        .DEPTH   (IQ_DEPTH),
        .entry_t (iq_entry_t)
    ) u_iq (
        .clk         (clk),
        .rst         (rst),
        .push_i      (enq),
        .pop_i       (deq),
        .clear_i     (rdy && flush),
        .push_data_i (iq_push),
        .head_o      (iq_head),
        .full_o      (iq_full),
        .empty_o     (iq_empty)
    );

endmodule

// File: tb/tb_ifetch_queue_unit.sv
// Scoreboard bench: the expected dispatch stream is the predicted program
// path walked from the reset/flush PC; a monitor pops it on each handshake.
module tb_ifetch_queue_unit;
    localparam int AW = 32;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy;
    logic [AW-1:0] pc_to_predictor;
    logic [IW-1:0] code_to_predictor;
    logic          pred_jump_from_predictor;
    logic [AW-1:0] pc_pred_from_predictor;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ok;
    logic [IW-1:0] mem_ins;
    logic          dsp_valid;
    logic          dsp_ready;
    logic [AW-1:0] dsp_pc;
    logic [IW-1:0] dsp_ins;
    logic [AW-1:0] dsp_pc_pred;
    logic          dsp_pred_jump;
    logic          flush;
    logic [AW-1:0] flush_pc;

    always #5 clk = ~clk;

    ifetch_queue_unit #(.ADDR_W(AW), .INS_W(IW), .IC_LINES(16), .IQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .pc_to_predictor(pc_to_predictor), .code_to_predictor(code_to_predictor),
        .pred_jump_from_predictor(pred_jump_from_predictor),
        .pc_pred_from_predictor(pc_pred_from_predictor),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ok(mem_ok), .mem_ins(mem_ins),
        .dsp_valid(dsp_valid), .dsp_ready(dsp_ready), .dsp_pc(dsp_pc), .dsp_ins(dsp_ins),
        .dsp_pc_pred(dsp_pc_pred), .dsp_pred_jump(dsp_pred_jump),
        .flush(flush), .flush_pc(flush_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pj;
        logic [31:0] pp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] gen_pc;
    int checks = 0, errors = 0;
    int n_disp = 0, n_req = 0, mode = 0;
    int p_ready = 100, p_rdy = 100, p_flush = 0;
    logic busy = 1'b0, arm_flush = 1'b0, fired = 1'b0;
    int lat = 0;
    logic [31:0] req_addr, first_req, flushed_addr;

    // Branch rule: low nibble 0xB jumps to ins[15:8]*4, else falls through.
    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] ins);
        return (ins[3:0] == 4'hB) ? {22'd0, ins[15:8], 2'b00} : pc + 32'd4;
    endfunction

    // Program image: straight-line code below 0x20 (loop back at 0xC in mode 0).
    function automatic logic [31:0] prog(input logic [31:0] a);
        logic [31:0] h;
        if (a < 32'h20) begin
            if (mode == 0 && a == 32'h0C) return 32'h000C_000B;
            return {a[15:0], 16'h0010};
        end
        h = a * 32'h9E3779B1;
        h = h ^ (h >> 15);
        if (h[5:4] == 2'b00)      h[3:0] = 4'hB;
        else if (h[3:0] == 4'hB)  h[3:0] = 4'h1;
        return h;
    endfunction

    assign pred_jump_from_predictor = (code_to_predictor[3:0] == 4'hB);
    assign pc_pred_from_predictor   = next_pc(pc_to_predictor, code_to_predictor);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic top_up();
        exp_t e;
        while (exp_q.size() < 16) begin
            e.pc  = gen_pc;
            e.ins = prog(gen_pc);
            e.pj  = (e.ins[3:0] == 4'hB);
            e.pp  = next_pc(gen_pc, e.ins);
            exp_q.push_back(e);
            gen_pc = e.pp;
        end
    endtask

    task automatic restart(input logic [31:0] start);
        exp_q.delete();
        gen_pc = start;
        top_up();
    endtask

    // One cycle of stimulus: control inputs, optional flush, memory responder.
    task automatic cycle();
        logic hold;
        hold = 1'b0;
        @(negedge clk);
        rdy       = ($urandom_range(0, 99) < p_rdy);
        dsp_ready = ($urandom_range(0, 99) < p_ready);
        flush     = 1'b0;
        if (arm_flush && mem_req && !busy && n_req == 8) begin
            rdy = 1'b1; flush = 1'b1; flush_pc = 32'h100;
            flushed_addr = mem_addr;
            restart(32'h100);
            arm_flush = 1'b0; fired = 1'b1; hold = 1'b1;
        end else if (rdy && $urandom_range(0, 999) < p_flush) begin
            flush = 1'b1;
            flush_pc = {22'd0, 8'($urandom), 2'b00};
            restart(flush_pc);
        end
        if (mem_ok) begin
            mem_ok = 1'b0;
        end else if (mem_req) begin
            if (!busy) begin
                busy = 1'b1; lat = $urandom_range(0, 3); req_addr = mem_addr;
                if (n_req == 0) first_req = mem_addr;
                n_req++;
            end
            if (lat == 0) begin
                if (rdy && !hold) begin
                    mem_ok = 1'b1; mem_ins = prog(req_addr); busy = 1'b0;
                end
            end else begin
                lat--;
            end
        end
        top_up();
    endtask

    task automatic do_reset(input int m);
        @(negedge clk);
        rst = 1'b1; mem_ok = 1'b0; busy = 1'b0; flush = 1'b0;
        mode = m;
        restart(32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every accepted head must match the next expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && rdy && dsp_valid && dsp_ready && !flush) begin
                n_disp++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: actual pc %h required none", dsp_pc);
                end else begin
                    e = exp_q.pop_front();
                    $display("dispatch pc=%h ins=%h pj=%0d pp=%h", dsp_pc, dsp_ins, dsp_pred_jump, dsp_pc_pred);
                    chk("dsp_pc", dsp_pc, e.pc);
                    chk("dsp_ins", dsp_ins, e.ins);
                    chk("dsp_pred_jump", 32'(dsp_pred_jump), 32'(e.pj));
                    chk("dsp_pc_pred", dsp_pc_pred, e.pp);
                end
            end
        end
    end

    initial begin
        int d0;
        logic found;
        rdy = 1'b0; dsp_ready = 1'b0; mem_ok = 1'b0; mem_ins = '0;
        flush = 1'b0; flush_pc = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_dsp_valid", 32'(dsp_valid), 0);
        chk("rst_dsp_pc", dsp_pc, 0);
        chk("rst_dsp_ins", dsp_ins, 0);
        chk("rst_dsp_pc_pred", dsp_pc_pred, 0);
        chk("rst_dsp_pred_jump", 32'(dsp_pred_jump), 0);
        chk("rst_pc_to_pred", pc_to_predictor, 0);
        chk("rst_code_to_pred", code_to_predictor, 0);

        // Loop 0x0..0xC: four cold misses, then hits at one per cycle.
        do_reset(0);
        n_req = 0; p_ready = 100; p_rdy = 100; p_flush = 0;
        repeat (40) cycle();
        chk("loop_misses", 32'(n_req), 4);
        #3 d0 = n_disp;
        repeat (20) cycle();
        #3 chk("hit_throughput", 32'(n_disp - d0), 20);
        p_ready = 0;
        d0 = n_disp;
        repeat (10) cycle();
        #3;
        chk("stall_no_dispatch", 32'(n_disp - d0), 0);
        chk("stall_valid", 32'(dsp_valid), 1);
        chk("stall_no_req", 32'(mem_req), 0);
        p_ready = 100;
        repeat (30) cycle();
        chk("loop_misses_after_stall", 32'(n_req), 4);

        // Cold sequential start, then flush to 0x100 while missing on 0x20.
        do_reset(1);
        n_req = 0; arm_flush = 1'b1;
        for (int i = 0; i < 300 && !fired; i++) cycle();
        chk("miss_flush_fired", 32'(fired), 1);
        chk("flushed_miss_addr", flushed_addr, 32'h20);
        d0 = n_disp;
        repeat (40) cycle();
        #3 chk("progress_after_flush", 32'(n_disp - d0 > 0), 1);

        // Random traffic with back-pressure, rdy gaps and flushes.
        p_ready = 70; p_rdy = 90; p_flush = 30;
        repeat (3000) cycle();

        // Asynchronous reset in the middle of a miss.
        p_flush = 0;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            cycle();
            #1 if (mem_req) found = 1'b1;
        end
        chk("found_miss_for_reset", 32'(found), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 0);
        chk("async_rst_dsp_valid", 32'(dsp_valid), 0);
        mem_ok = 1'b0; busy = 1'b0; flush = 1'b0;
        restart(32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_req = 0; p_ready = 80; p_rdy = 100;
        d0 = n_disp;
        repeat (400) cycle();
        chk("restart_first_miss", first_req, 32'h0);
        #3 chk("progress_after_reset", 32'(n_disp - d0 > 50), 1);
        chk("total_progress", 32'(n_disp > 1000), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
